// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor: default operand width and FSM state encoding.
package sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

endpackage

// File: rtl/full_sub_1.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
module full_sub_1 (
  input  logic bin,
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: DIFF = A - B - BIN, one bit per clock, start/busy/done handshake.
module serial_sub
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-2:0] d_sh_q, d_sh_d;
  logic             borrow_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q, bout_q;
  logic [WIDTH-1:0] diff_q;
  logic             d_w, bo_w;

  full_sub_1 u_full_sub (
    .bin  (borrow_q),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .diff (d_w),
    .bout (bo_w)
  );

  // Partial result fills from the MSB side; the final bit is merged straight into DIFF.
  assign d_sh_d = (WIDTH-1)'({d_w, d_sh_q} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q   <= A;
            b_sh_q   <= B;
            borrow_q <= BIN;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StShift;
          end
        end
        StShift: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          d_sh_q   <= d_sh_d;
          borrow_q <= bo_w;
          if (cnt_q == CntLast) begin
            diff_q  <= {d_w, d_sh_q};
            bout_q  <= bo_w;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign DIFF = diff_q;
  assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Randomized self-checking bench for serial_sub at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_serial_sub;

  logic       clk, rst_n;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .BIN(bin4),
    .busy(busy4), .done(done4), .DIFF(diff4), .BOUT(bout4)
  );

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .BIN(bin8),
    .busy(busy8), .done(done8), .DIFF(diff8), .BOUT(bout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain modular arithmetic and comparison.
  function automatic logic [7:0] ref_diff(int w, int a, int b, int bin);
    int r;
    r = (a - b - bin) % (1 << w);
    if (r < 0) r += (1 << w);
    return 8'(r);
  endfunction

  function automatic logic ref_bout(int a, int b, int bin);
    return a < (b + bin);
  endfunction

  function automatic logic cur_done(bit wide);
    return wide ? done8 : done4;
  endfunction

  function automatic logic cur_busy(bit wide);
    return wide ? busy8 : busy4;
  endfunction

  // Starts at a negedge, returns at the negedge where done is seen (so the next call is back-to-back).
  task automatic run_op(input bit wide, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] diff, output logic bout, output int lat,
                        output int busy_n);
    if (wide) begin
      start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    end else begin
      start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; bin4 = bin;
    end
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!cur_done(wide) && lat < 40) begin
      if (cur_busy(wide)) busy_n++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(cur_done(wide)), 32'd1);
    check("busy_low_at_done", 32'(cur_busy(wide)), 32'd0);
    diff = wide ? diff8 : {4'h0, diff4};
    bout = wide ? bout8 : bout4;
  endtask

  initial begin : stim
    logic [7:0] d;
    logic       bo;
    int         lat, bn, cnt, last;
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];
    va = '{8'd9, 8'd3, 8'd0, 8'd15};
    vb = '{8'd3, 8'd9, 8'd0, 8'd15};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0};

    start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy4), 0);
    check("rst_done", 32'(done4), 0);
    check("rst_diff", 32'(diff4), 0);
    check("rst_bout", 32'(bout4), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy4), 0);

    // Directed vectors with latency and busy-length checks.
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, va[i], vb[i], vc[i], d, bo, lat, bn);
      check("dir_diff", 32'(d), 32'(ref_diff(4, int'(va[i]), int'(vb[i]), int'(vc[i]))));
      check("dir_bout", 32'(bo), 32'(ref_bout(int'(va[i]), int'(vb[i]), int'(vc[i]))));
      check("dir_latency", 32'(lat), 32'd4);
      check("dir_busy_len", 32'(bn), 32'd4);
    end

    // Start while busy must be ignored.
    @(negedge clk);
    start4 = 1; a4 = 4'd5; b4 = 4'd2; bin4 = 0;
    @(posedge clk); @(negedge clk);
    start4 = 0;
    @(negedge clk);
    start4 = 1; a4 = 4'd1; b4 = 4'd8;
    @(negedge clk);
    @(negedge clk);
    start4 = 0;
    @(negedge clk);
    check("ign_done", 32'(done4), 1);
    check("ign_diff", 32'(diff4), 32'd3);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4 || busy4) cnt++;
    end
    check("ign_no_second", 32'(cnt), 0);

    // Start held high: one result every WIDTH+1 cycles.
    start4 = 1; a4 = 4'd7; b4 = 4'd1; bin4 = 0;
    cnt = 0; last = 0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (done4) begin
        cnt++;
        check("held_diff", 32'(diff4), 32'd6);
        if (last != 0) check("held_period", 32'(k - last), 32'd5);
        last = k;
      end
    end
    start4 = 0;
    check("held_pulses", 32'(cnt), 32'd4);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4) cnt++;
    end
    check("held_drain", 32'(cnt), 32'd1);

    // Reset mid-operation.
    run_op(1'b0, 8'd7, 8'd1, 1'b0, d, bo, lat, bn);
    check("pre_rst_diff", 32'(d), 32'd6);
    start4 = 1; a4 = 4'd9; b4 = 4'd3; bin4 = 0;
    @(posedge clk); @(negedge clk);
    start4 = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy4), 0);
    check("abort_done", 32'(done4), 0);
    check("abort_diff", 32'(diff4), 0);
    check("abort_bout", 32'(bout4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 || busy4) cnt++;
    end
    check("abort_quiet", 32'(cnt), 0);
    run_op(1'b0, 8'd9, 8'd3, 1'b0, d, bo, lat, bn);
    check("post_rst_diff", 32'(d), 32'd6);
    check("post_rst_lat", 32'(lat), 32'd4);

    // Exhaustive WIDTH=4, back-to-back.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          run_op(1'b0, 8'(a), 8'(b), 1'(c), d, bo, lat, bn);
          check("exh_diff", 32'(d), 32'(ref_diff(4, a, b, c)));
          check("exh_bout", 32'(bo), 32'(ref_bout(a, b, c)));
        end

    // Random WIDTH=8 regression.
    for (int i = 0; i < 3000; i++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(255, 0));
      rb = int'($urandom_range(255, 0));
      rc = int'($urandom_range(1, 0));
      run_op(1'b1, 8'(ra), 8'(rb), 1'(rc), d, bo, lat, bn);
      check("rnd8_diff", 32'(d), 32'(ref_diff(8, ra, rb, rc)));
      check("rnd8_bout", 32'(bo), 32'(ref_bout(ra, rb, rc)));
      if (i == 0) check("rnd8_latency", 32'(lat), 32'd8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
